// File: rtl/myproject_mul_arb.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
// Define MYPROJECT_MUL_ARB_SAT_EN to saturate the result instead of wrapping it.
module myproject_mul_arb #(
   parameter int NUM_REQ     = 4,
   parameter int DIN0_WIDTH  = 33,
   parameter int DIN1_WIDTH  = 9,
   parameter int DOUT_WIDTH  = 36,
   parameter int MUL_LATENCY = 2,
   parameter int TAG_WIDTH   = 2
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DOUT_WIDTH-1:0]            out_dout,
   output logic [TAG_WIDTH-1:0]             out_tag,
   output logic [2:0]                       inflight
);

   localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

   logic                   stall;
   logic                   run;
   logic                   hs;
   logic                   found;
   logic [NUM_REQ-1:0]     grant;
   logic [TAG_WIDTH-1:0]   gidx;
   logic [TAG_WIDTH-1:0]   rr_ptr;
   logic [TAG_WIDTH-1:0]   ptr_nxt;
   logic [DIN0_WIDTH-1:0]  opa;
   logic [DIN1_WIDTH-1:0]  opb;
   logic signed [PW-1:0]   ea;
   logic signed [PW-1:0]   eb;
   logic signed [PW-1:0]   prod;
   logic signed [PW-1:0]   p_last;
   int                     j;

   logic [MUL_LATENCY-1:0] v_q;
   logic signed [PW-1:0]   p_q [MUL_LATENCY];
   logic [TAG_WIDTH-1:0]   t_q [MUL_LATENCY];

   assign stall = out_valid & ~out_ready;
   assign run   = ~stall & ap_rst_n;

   // Search upward from rr_ptr with wrap; first valid requester wins.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      opa   = '0;
      opb   = '0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            gidx     = TAG_WIDTH'(j);
            opa      = req_din0[j*DIN0_WIDTH +: DIN0_WIDTH];
            opb      = req_din1[j*DIN1_WIDTH +: DIN1_WIDTH];
         end
      end
   end

   assign req_ready = grant & {NUM_REQ{run}};
   assign hs        = found & run;
   assign ptr_nxt   = (gidx == TAG_WIDTH'(NUM_REQ-1)) ? '0 : gidx + 1'b1;

   assign ea   = {{DIN1_WIDTH{opa[DIN0_WIDTH-1]}}, opa};
   assign eb   = {{DIN0_WIDTH{opb[DIN1_WIDTH-1]}}, opb};
   assign prod = ea * eb;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rr_ptr <= '0;
         v_q    <= '0;
         for (int i = 0; i < MUL_LATENCY; i++) begin
            p_q[i] <= '0;
            t_q[i] <= '0;
         end
      end else if (!stall) begin
         if (hs) rr_ptr <= ptr_nxt;
         v_q[0] <= hs;
         p_q[0] <= prod;
         t_q[0] <= gidx;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            v_q[i] <= v_q[i-1];
            p_q[i] <= p_q[i-1];
            t_q[i] <= t_q[i-1];
         end
      end
   end

   assign out_valid = v_q[MUL_LATENCY-1];
   assign out_tag   = t_q[MUL_LATENCY-1];
   assign p_last    = p_q[MUL_LATENCY-1];

`ifdef MYPROJECT_MUL_ARB_SAT_EN
   if (DOUT_WIDTH < PW) begin : g_sat
      logic [PW-DOUT_WIDTH:0] hi;
      assign hi = p_last[PW-1:DOUT_WIDTH-1];
      // In range only when all bits above the result sign agree with it.
      always_comb begin
         if (&hi || ~|hi)
            out_dout = p_last[DOUT_WIDTH-1:0];
         else if (p_last[PW-1])
            out_dout = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
         else
            out_dout = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      end
   end else begin : g_full
      assign out_dout = p_last[DOUT_WIDTH-1:0];
   end
`else
   assign out_dout = p_last[DOUT_WIDTH-1:0];
`endif

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MUL_LATENCY; i++)
         inflight = inflight + 3'(v_q[i]);
   end

endmodule

// File: tb/tb_myproject_mul_arb.sv
// Directed self-checking bench for myproject_mul_arb (default parameters).
// Expected overflow results follow MYPROJECT_MUL_ARB_SAT_EN when defined.
module tb_myproject_mul_arb;

   logic         ap_clk;
   logic         ap_rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [131:0] req_din0;
   logic [35:0]  req_din1;
   logic         out_valid;
   logic         out_ready;
   logic [35:0]  out_dout;
   logic [1:0]   out_tag;
   logic [2:0]   inflight;

   int total = 0;
   int bad   = 0;

   myproject_mul_arb dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_din0  (req_din0),
      .req_din1  (req_din1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dout  (out_dout),
      .out_tag   (out_tag),
      .inflight  (inflight)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic run_one(input int lane, input logic [32:0] a,
                          input logic [8:0] b, output logic [35:0] d,
                          output logic [1:0] t, output int lat);
      int w;
      req_din0[lane*33 +: 33] = a;
      req_din1[lane*9 +: 9]   = b;
      req_valid = 4'(1 << lane);
      #1;
      w = 0;
      while (!req_ready[lane] && w < 10) begin
         tick();
         w++;
      end
      check("one_grant", 64'(req_ready[lane]), 64'd1);
      tick();
      req_valid = '0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      d = out_dout;
      t = out_tag;
   endtask

   logic [35:0] ed;
   logic [35:0] d;
   logic [35:0] prev_d;
   logic [3:0]  er;
   logic [1:0]  et;
   logic [1:0]  t;
   logic [1:0]  prev_t;
   logic [35:0] q [$];
   int          lat;
   int          sent;
   int          recv;
   int          stall_cnt;
   logic        was_stall;
   logic        now_stall;

   initial begin
      ap_rst_n  = 1'b0;
      req_valid = '0;
      req_din0  = '0;
      req_din1  = '0;
      out_ready = 1'b1;

      // reset state
      #2;
      req_valid = 4'hF;
      #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_dout", 64'(out_dout), 64'd0);
      check("rst_tag", 64'(out_tag), 64'd0);
      tick();
      req_valid = '0;
      ap_rst_n  = 1'b1;

      // fairness: all four valid for 8 grants
      for (int i = 0; i < 4; i++) begin
         req_din0[i*33 +: 33] = 33'(i + 1);
         req_din1[i*9 +: 9]   = 9'(10 + i);
      end
      for (int c = 0; c < 11; c++) begin
         req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         er = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
         check("fair_ready", 64'(req_ready), 64'(er));
         if (c >= 2 && c < 10) begin
            et = 2'((c - 2) % 4);
            ed = 36'((int'(et) + 1) * (10 + int'(et)));
            check("fair_valid", 64'(out_valid), 64'd1);
            check("fair_tag", 64'(out_tag), 64'(et));
            check("fair_dout", 64'(out_dout), 64'(ed));
         end
         tick();
      end
      check("fair_drain", 64'(out_valid), 64'd0);

      // single product from requester 2: 3 * -5
      req_din0[2*33 +: 33] = 33'd3;
      req_din1[2*9 +: 9]   = 9'h1FB;
      req_valid = 4'b0100;
      #1;
      check("sp_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      #1;
      check("sp_ready_off", 64'(req_ready), 64'h0);
      check("sp_inflight1", 64'(inflight), 64'd1);
      check("sp_valid_early", 64'(out_valid), 64'd0);
      tick();
      ed = 36'hFFFFFFFF1;
      check("sp_valid", 64'(out_valid), 64'd1);
      check("sp_dout", 64'(out_dout), 64'(ed));
      check("sp_tag", 64'(out_tag), 64'd2);
      tick();
      check("sp_valid_off", 64'(out_valid), 64'd0);
      check("sp_inflight0", 64'(inflight), 64'd0);

      // backpressure: stream from requester 1, out_ready low 3 cycles
      sent = 0;
      recv = 0;
      stall_cnt = 0;
      was_stall = 1'b0;
      prev_d = '0;
      prev_t = '0;
      req_din1[1*9 +: 9] = 9'h1FD;
      for (int it = 0; it < 16; it++) begin
         out_ready = !(it >= 3 && it < 6);
         req_valid = (sent < 6) ? 4'b0010 : 4'b0000;
         req_din0[1*33 +: 33] = 33'(sent + 1);
         #1;
         now_stall = out_valid && !out_ready;
         if (now_stall) begin
            stall_cnt++;
            check("bp_ready_stall", 64'(req_ready), 64'd0);
            if (was_stall) begin
               check("bp_dout_frozen", 64'(out_dout), 64'(prev_d));
               check("bp_tag_frozen", 64'(out_tag), 64'(prev_t));
            end
         end
         if (req_valid[1] && req_ready[1]) begin
            ed = 36'(-3 * (sent + 1));
            q.push_back(ed);
         end
         if (out_valid && out_ready) begin
            check("bp_nonempty", 64'(q.size() > 0), 64'd1);
            check("bp_tag", 64'(out_tag), 64'd1);
            if (q.size() > 0) begin
               ed = q.pop_front();
               check("bp_dout", 64'(out_dout), 64'(ed));
            end
            recv++;
         end
         prev_d = out_dout;
         prev_t = out_tag;
         was_stall = now_stall;
         if (req_valid[1] && req_ready[1]) sent++;
         tick();
      end
      out_ready = 1'b1;
      check("bp_stalls", 64'(stall_cnt), 64'd3);
      check("bp_recv", 64'(recv), 64'd6);
      check("bp_left", 64'(q.size()), 64'd0);

      // overflow: (2^32-1) * -256
      run_one(0, 33'h0FFFFFFFF, 9'h100, d, t, lat);
`ifdef MYPROJECT_MUL_ARB_SAT_EN
      ed = 36'h800000000;
`else
      ed = 36'h000000100;
`endif
      check("ovf_lat", 64'(lat), 64'd2);
      check("ovf_dout", 64'(d), 64'(ed));
      check("ovf_tag", 64'(t), 64'd0);
      tick();

      // extreme: -2^32 * -256 = 2^40
      run_one(0, 33'h100000000, 9'h100, d, t, lat);
`ifdef MYPROJECT_MUL_ARB_SAT_EN
      ed = 36'h7FFFFFFFF;
`else
      ed = 36'h000000000;
`endif
      check("ext_lat", 64'(lat), 64'd2);
      check("ext_dout", 64'(d), 64'(ed));
      tick();

      // reset mid-flight: lanes 1 and 2 accepted, then reset pulse
      req_din0[1*33 +: 33] = 33'd5;
      req_din1[1*9 +: 9]   = 9'd5;
      req_din0[2*33 +: 33] = 33'd9;
      req_din1[2*9 +: 9]   = 9'd9;
      req_valid = 4'b0110;
      tick();
      tick();
      req_valid = '0;
      check("rm_inflight2", 64'(inflight), 64'd2);
      check("rm_valid_pre", 64'(out_valid), 64'd1);
      #2;
      ap_rst_n  = 1'b0;
      req_valid = 4'b1001;
      #1;
      check("rm_valid", 64'(out_valid), 64'd0);
      check("rm_inflight", 64'(inflight), 64'd0);
      check("rm_ready", 64'(req_ready), 64'd0);
      tick();
      req_din0[0*33 +: 33] = 33'd7;
      req_din1[0*9 +: 9]   = 9'd6;
      ap_rst_n = 1'b1;
      #1;
      check("rm_first_grant", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      check("rm_no_stale", 64'(out_valid), 64'd0);
      tick();
      check("rm_post_valid", 64'(out_valid), 64'd1);
      check("rm_post_tag", 64'(out_tag), 64'd0);
      check("rm_post_dout", 64'(out_dout), 64'd42);
      tick();
      check("rm_end_valid", 64'(out_valid), 64'd0);
      check("rm_end_inflight", 64'(inflight), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
